// File: rtl/alu_arbiter_if.sv
// Bus bundle between two ALU requesters, the arbiter and the shared ALU.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_alucontrol;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_alucontrol;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_alucontrol;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic [15:0]      ops_done;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_alucontrol,
    input  req1_valid, req1_a, req1_b, req1_alucontrol,
    input  rsp0_ready, rsp1_ready, alu_result, alu_zero,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, rsp_zero, alu_a, alu_b, alu_alucontrol, ops_done
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_alucontrol,
    output req1_valid, req1_a, req1_b, req1_alucontrol,
    output rsp0_ready, rsp1_ready, alu_result, alu_zero,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_zero, alu_a, alu_b, alu_alucontrol, ops_done
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU.
// Each operation runs IDLE (accept) -> EXEC (ALU settles) -> RESP (held until consumed).
//
//   state | meaning
//   IDLE  | no operation in flight; grant offered to a valid requester
//   EXEC  | operand regs drive the ALU; result captured at end of cycle
//   RESP  | result held for the owner until its rsp_ready is seen
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_ctl;
  logic             r_owner;
  logic             r_last;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic [15:0]      r_ops_done;

  logic w_grant0;
  logic w_grant1;
  logic w_acc0;
  logic w_acc1;
  logic w_rsp_take;

  // On a tie the requester that was not served last wins.
  assign w_grant0 = bus.req0_valid & (~bus.req1_valid | r_last);
  assign w_grant1 = bus.req1_valid & (~bus.req0_valid | ~r_last);

  assign bus.req0_ready = (r_state == IDLE) & w_grant0 & ~reset;
  assign bus.req1_ready = (r_state == IDLE) & w_grant1 & ~reset;

  assign w_acc0     = bus.req0_valid & bus.req0_ready;
  assign w_acc1     = bus.req1_valid & bus.req1_ready;
  assign w_rsp_take = r_owner ? bus.rsp1_ready : bus.rsp0_ready;

  assign bus.alu_a          = r_a;
  assign bus.alu_b          = r_b;
  assign bus.alu_alucontrol = r_ctl;
  assign bus.rsp_result     = r_result;
  assign bus.rsp_zero       = r_zero;
  assign bus.rsp0_valid     = r_rsp0_valid;
  assign bus.rsp1_valid     = r_rsp1_valid;
  assign bus.ops_done       = r_ops_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_ctl        <= '0;
      r_owner      <= 1'b0;
      r_last       <= 1'b1;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_ops_done   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc0 | w_acc1) begin
            r_a     <= w_acc1 ? bus.req1_a : bus.req0_a;
            r_b     <= w_acc1 ? bus.req1_b : bus.req0_b;
            r_ctl   <= w_acc1 ? bus.req1_alucontrol : bus.req0_alucontrol;
            r_owner <= w_acc1;
            r_last  <= w_acc1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_result     <= bus.alu_result;
          r_zero       <= bus.alu_zero;
          r_rsp0_valid <= ~r_owner;
          r_rsp1_valid <= r_owner;
          r_state      <= RESP;
        end
        RESP: begin
          if (w_rsp_take) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_ops_done   <= r_ops_done + 16'd1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU closes the loop and a
// negedge monitor scores every consumed response against a queue filled at accept.
module tb_alu_arbiter;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();
  alu_arbiter #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic             owner;
    logic [WIDTH-1:0] result;
    logic             zero;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   acc_cyc[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [2:0] c);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a ^ b;
      3'b011:  return a << b[4:0];
      3'b100:  return ~(a | b);
      3'b101:  return (a < b) ? 1 : 0;
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_alucontrol);
  assign bus.alu_zero   = ~|bus.alu_result;

  always @(posedge clk) cyc++;

  // Scoreboard monitor: push at accept, pop and compare at consume.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      n_cmp++;
      if ((bus.req0_ready & bus.req1_ready) !== 1'b0) begin
        n_err++;
        $display("FAIL ready_excl: req0_ready=%b req1_ready=%b, want not both", bus.req0_ready, bus.req1_ready);
      end
      n_cmp++;
      if ((bus.rsp0_valid & bus.rsp1_valid) !== 1'b0) begin
        n_err++;
        $display("FAIL rsp_excl: rsp0_valid=%b rsp1_valid=%b, want not both", bus.rsp0_valid, bus.rsp1_valid);
      end
      if (bus.req0_valid && bus.req0_ready) begin
        mon_e.owner  = 1'b0;
        mon_e.result = alu_f(bus.req0_a, bus.req0_b, bus.req0_alucontrol);
        mon_e.zero   = (mon_e.result == '0);
        sb.push_back(mon_e);
        grants.push_back(0);
        acc_cyc.push_back(cyc);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        mon_e.owner  = 1'b1;
        mon_e.result = alu_f(bus.req1_a, bus.req1_b, bus.req1_alucontrol);
        mon_e.zero   = (mon_e.result == '0);
        sb.push_back(mon_e);
        grants.push_back(1);
        acc_cyc.push_back(cyc);
      end
      if ((bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready)) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_pop: response owner=%b result=%0h with no pending op", bus.rsp1_valid, bus.rsp_result);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.owner !== bus.rsp1_valid || mon_e.result !== bus.rsp_result || mon_e.zero !== bus.rsp_zero) begin
            n_err++;
            $display("FAIL sb_rsp: got owner=%b result=%0h zero=%b, want owner=%b result=%0h zero=%b",
                     bus.rsp1_valid, bus.rsp_result, bus.rsp_zero, mon_e.owner, mon_e.result, mon_e.zero);
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_alucontrol = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_alucontrol = '0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sb.delete(); grants.delete(); acc_cyc.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.req0_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready0: got %b want 0", bus.req0_ready); end
    n_cmp++; if (bus.req1_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready1: got %b want 0", bus.req1_ready); end
    n_cmp++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 00", {bus.rsp0_valid, bus.rsp1_valid}); end
    n_cmp++; if (bus.rsp_result !== '0 || bus.rsp_zero !== 1'b0) begin n_err++; $display("FAIL rst_rsp: got %0h/%b want 0/0", bus.rsp_result, bus.rsp_zero); end
    n_cmp++; if (bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_alucontrol !== 3'b000) begin n_err++; $display("FAIL rst_alu: got %0h/%0h/%b want 0/0/000", bus.alu_a, bus.alu_b, bus.alu_alucontrol); end
    n_cmp++; if (bus.ops_done !== 16'h0000) begin n_err++; $display("FAIL rst_ops: got %0h want 0", bus.ops_done); end
    @(posedge clk);
    #1 reset = 1'b0;
    idle_inputs();
    sb.delete(); grants.delete(); acc_cyc.delete();
  endtask

  task automatic test_single();
    @(posedge clk);
    #1 bus.req0_a = 32'd5; bus.req0_b = 32'd6; bus.req0_alucontrol = 3'b111; bus.req0_valid = 1'b1; bus.rsp0_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin n_err++; $display("FAIL single_ready: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
    @(posedge clk);
    #1 bus.req0_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd6 || bus.alu_alucontrol !== 3'b111) begin n_err++; $display("FAIL single_alu: got %0h/%0h/%b want 5/6/111", bus.alu_a, bus.alu_b, bus.alu_alucontrol); end
    n_cmp++; if (bus.rsp0_valid !== 1'b0) begin n_err++; $display("FAIL single_early: rsp0_valid=%b want 0 in EXEC", bus.rsp0_valid); end
    @(negedge clk);
    n_cmp++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b10) begin n_err++; $display("FAIL single_valid: got %b want 10", {bus.rsp0_valid, bus.rsp1_valid}); end
    n_cmp++; if (bus.rsp_result !== 32'd4 || bus.rsp_zero !== 1'b0) begin n_err++; $display("FAIL single_result: got %0h/%b want 4/0", bus.rsp_result, bus.rsp_zero); end
    @(negedge clk);
    n_cmp++; if (bus.rsp0_valid !== 1'b0 || bus.ops_done !== 16'd1) begin n_err++; $display("FAIL single_done: rsp0_valid=%b ops_done=%0d want 0/1", bus.rsp0_valid, bus.ops_done); end
  endtask

  task automatic test_tie();
    int order[$];
    logic [WIDTH-1:0] r0, r1;
    logic z0, z1, a0, a1;
    r0 = 'x; r1 = 'x; z0 = 1'bx; z1 = 1'bx;
    idle_inputs();
    do_reset();
    bus.req0_a = 32'h5555_5555; bus.req0_b = 32'hAAAA_AAAA; bus.req0_alucontrol = 3'b111; bus.req0_valid = 1'b1;
    bus.req1_a = 32'd5; bus.req1_b = 32'd6; bus.req1_alucontrol = 3'b110; bus.req1_valid = 1'b1;
    for (int c = 0; c < 20 && order.size() < 2; c++) begin
      @(negedge clk);
      a0 = bus.req0_valid & bus.req0_ready;
      a1 = bus.req1_valid & bus.req1_ready;
      if (bus.rsp0_valid && bus.rsp0_ready) begin order.push_back(0); r0 = bus.rsp_result; z0 = bus.rsp_zero; end
      if (bus.rsp1_valid && bus.rsp1_ready) begin order.push_back(1); r1 = bus.rsp_result; z1 = bus.rsp_zero; end
      @(posedge clk);
      #1;
      if (a0) bus.req0_valid = 1'b0;
      if (a1) bus.req1_valid = 1'b0;
    end
    n_cmp++;
    if (order.size() != 2) begin n_err++; $display("FAIL tie_timeout: got %0d responses want 2", order.size()); end
    else if (order[0] != 0 || order[1] != 1) begin n_err++; $display("FAIL tie_order: got %0d,%0d want 0,1", order[0], order[1]); end
    n_cmp++; if (r0 !== '0 || z0 !== 1'b1) begin n_err++; $display("FAIL tie_r0: got %0h/%b want 0/1", r0, z0); end
    n_cmp++; if (r1 !== 32'd7 || z1 !== 1'b0) begin n_err++; $display("FAIL tie_r1: got %0h/%b want 7/0", r1, z1); end
  endtask

  task automatic test_alternate();
    int iss0, iss1;
    logic a0, a1;
    iss0 = 0; iss1 = 0;
    idle_inputs();
    do_reset();
    bus.req0_a = $urandom; bus.req0_b = $urandom; bus.req0_alucontrol = 3'($urandom_range(0, 7)); bus.req0_valid = 1'b1;
    bus.req1_a = $urandom; bus.req1_b = $urandom; bus.req1_alucontrol = 3'($urandom_range(0, 7)); bus.req1_valid = 1'b1;
    for (int c = 0; c < 40 && !(iss0 == 3 && iss1 == 3 && sb.size() == 0); c++) begin
      @(negedge clk);
      a0 = bus.req0_valid & bus.req0_ready;
      a1 = bus.req1_valid & bus.req1_ready;
      @(posedge clk);
      #1;
      if (a0) begin
        iss0++;
        if (iss0 == 3) bus.req0_valid = 1'b0;
        else begin bus.req0_a = $urandom; bus.req0_b = $urandom; bus.req0_alucontrol = 3'($urandom_range(0, 7)); end
      end
      if (a1) begin
        iss1++;
        if (iss1 == 3) bus.req1_valid = 1'b0;
        else begin bus.req1_a = $urandom; bus.req1_b = $urandom; bus.req1_alucontrol = 3'($urandom_range(0, 7)); end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (grants.size() != 6) begin n_err++; $display("FAIL alt_count: got %0d grants want 6", grants.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (grants[i] != i % 2) begin n_err++; $display("FAIL alt_grant%0d: got %0d want %0d", i, grants[i], i % 2); end
        if (i > 0) begin
          n_cmp++;
          if (acc_cyc[i] - acc_cyc[i-1] != 3) begin n_err++; $display("FAIL alt_interval%0d: got %0d want 3", i, acc_cyc[i] - acc_cyc[i-1]); end
        end
      end
    end
    n_cmp++; if (bus.ops_done !== 16'd6) begin n_err++; $display("FAIL alt_ops: got %0d want 6", bus.ops_done); end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    do_reset();
    bus.rsp1_ready = 1'b0; bus.rsp0_ready = 1'b1;
    bus.req1_a = '0; bus.req1_b = 32'hFFFF_FFFF; bus.req1_alucontrol = 3'b110; bus.req1_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req1_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept: req1_ready=%b want 1", bus.req1_ready); end
    @(posedge clk);
    #1 bus.req1_valid = 1'b0;
    bus.req0_a = 32'd1; bus.req0_b = 32'd2; bus.req0_alucontrol = 3'b000; bus.req0_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req0_ready !== 1'b0) begin n_err++; $display("FAIL bp_exec_ready: req0_ready=%b want 0", bus.req0_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.rsp1_valid, bus.rsp0_valid} !== 2'b10 || bus.rsp_result !== 32'hFFFF_FFFF || bus.rsp_zero !== 1'b0 ||
          {bus.req0_ready, bus.req1_ready} !== 2'b00 || bus.ops_done !== 16'd0) begin
        n_err++;
        $display("FAIL bp_hold%0d: v1/v0=%b%b res=%0h z=%b rdy=%b%b ops=%0d want 10 ffffffff 0 00 0", i,
                 bus.rsp1_valid, bus.rsp0_valid, bus.rsp_result, bus.rsp_zero, bus.req0_ready, bus.req1_ready, bus.ops_done);
      end
    end
    @(posedge clk);
    #1 bus.rsp1_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.ops_done !== 16'd1 || bus.rsp1_valid !== 1'b0 || bus.req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: ops=%0d rsp1_valid=%b req0_ready=%b want 1/0/1", bus.ops_done, bus.rsp1_valid, bus.req0_ready);
    end
    @(posedge clk);
    #1 bus.req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.rsp0_valid !== 1'b1 || bus.rsp_result !== 32'd3) begin n_err++; $display("FAIL bp_next: rsp0_valid=%b res=%0h want 1/3", bus.rsp0_valid, bus.rsp_result); end
    @(negedge clk);
    n_cmp++; if (bus.ops_done !== 16'd2) begin n_err++; $display("FAIL bp_ops: got %0d want 2", bus.ops_done); end
  endtask

  task automatic test_reset_exec();
    idle_inputs();
    @(posedge clk);
    #1 bus.req0_a = 32'd9; bus.req0_b = 32'd9; bus.req0_alucontrol = 3'b001; bus.req0_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL rx_accept: req0_ready=%b want 1", bus.req0_ready); end
    @(posedge clk);
    #1 bus.req0_valid = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    n_cmp++;
    if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00 || bus.rsp_result !== '0 || bus.rsp_zero !== 1'b0 ||
        bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_alucontrol !== 3'b000 || bus.ops_done !== 16'd0) begin
      n_err++;
      $display("FAIL rx_state: v=%b%b res=%0h z=%b alu=%0h/%0h/%b ops=%0d want all zero", bus.rsp0_valid, bus.rsp1_valid,
               bus.rsp_result, bus.rsp_zero, bus.alu_a, bus.alu_b, bus.alu_alucontrol, bus.ops_done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL rx_norsp%0d: got %b%b want 00", i, bus.rsp0_valid, bus.rsp1_valid); end
    end
  endtask

  task automatic test_wrap();
    idle_inputs();
    @(negedge clk);
    force dut.r_ops_done = 16'hFFFF;
    @(posedge clk);
    #1 release dut.r_ops_done;
    @(negedge clk);
    n_cmp++; if (bus.ops_done !== 16'hFFFF) begin n_err++; $display("FAIL wrap_pre: got %0h want ffff", bus.ops_done); end
    @(posedge clk);
    #1 bus.req1_a = 32'd3; bus.req1_b = 32'd3; bus.req1_alucontrol = 3'b001; bus.req1_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 bus.req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.rsp1_valid !== 1'b1 || bus.rsp_zero !== 1'b1) begin n_err++; $display("FAIL wrap_rsp: rsp1_valid=%b zero=%b want 1/1", bus.rsp1_valid, bus.rsp_zero); end
    @(negedge clk);
    n_cmp++; if (bus.ops_done !== 16'h0000) begin n_err++; $display("FAIL wrap_post: got %0h want 0", bus.ops_done); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_tie();
    test_alternate();
    test_backpressure();
    test_reset_exec();
    test_wrap();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: %0d ops never answered, want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width of the shared ArithmeticLogicUnit.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 presents an operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts the operation of requester 0/1 this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands of requester 0/1.
REQ-007 req0_alucontrol / req1_alucontrol  input  3  ALU opcode of requester 0/1; passed through unmodified.
REQ-008 rsp0_valid / rsp1_valid  output  1  response for requester 0/1 available.
REQ-009 rsp0_ready / rsp1_ready  input  1  requester 0/1 consumes its response.
REQ-010 rsp_result  output  WIDTH  registered ALU result of the operation in RESP.
REQ-011 rsp_zero  output  1  registered ALU zero flag of the operation in RESP.
REQ-012 alu_a, alu_b  output  WIDTH  operands to shared ALU.
REQ-013 alu_alucontrol  output  3  opcode to shared ALU.
REQ-014 alu_result  input  WIDTH, alu_zero  input  1  combinational outputs of shared ALU.
REQ-015 ops_done  output  16  count of completed (consumed) operations.

Function
REQ-016 The block SHALL implement FSM states IDLE, EXEC, RESP.
REQ-017 Grant (combinational, IDLE only): one valid -> that requester; both valid -> requester != last_served; none -> no grant.
REQ-018 reqN_ready SHALL equal (state==IDLE) & grantN; at most one ready high per cycle; never high in EXEC/RESP.
REQ-019 Accept = reqN_valid & reqN_ready: latch a, b, alucontrol into operand regs, record owner=N, set last_served=N, go EXEC.
REQ-020 alu_a/alu_b/alu_alucontrol SHALL be driven from operand regs at all times (stable throughout EXEC).
REQ-021 EXEC lasts exactly one cycle: at its end capture alu_result/alu_zero into rsp_result/rsp_zero, go RESP.
REQ-022 In RESP, rsp{owner}_valid=1, other rsp valid=0; rsp_result/rsp_zero SHALL stay stable until consumed.
REQ-023 RESP with rsp{owner}_ready=1 at a rising edge: go IDLE, ops_done += 1 (wraps 0xFFFF -> 0x0000); ready low: stay RESP.
REQ-024 rspN_ready of non-owner SHALL be ignored; reqN_valid in EXEC/RESP SHALL be ignored (requester holds it).
REQ-025 Latency: accept at edge E -> rsp valid visible after edge E+2; min issue interval 3 cycles with rsp_ready tied high.
REQ-026 Under continuous dual requests grants SHALL strictly alternate 0,1,0,1...
REQ-027 Opcode and operand values SHALL NOT be checked or altered; any 3-bit alucontrol is forwarded.

Reset
REQ-028 reset high at a rising edge: state=IDLE, operand regs=0, alu_* outputs=0, rsp_result=0, rsp_zero=0, rsp valids=0, ops_done=0, last_served=1 (requester 0 wins first tie).
REQ-029 reset SHALL override any other event in the same cycle; an in-flight EXEC/RESP op is discarded, no response issued, ops_done not incremented.
REQ-030 During reset cycles reqN_ready SHALL be 0.

Verification
REQ-031 req0 a=5, b=6, ctl=3'b111, rsp0_ready=1 -> req0_ready same cycle, alu_* =5/6/111 in EXEC, rsp0_valid after 2 edges with rsp_result=4, rsp_zero=0, ops_done=1.
REQ-032 After reset both valid (req0 AND 0x55555555/0xAAAAAAAA, req1 OR 5/6 ctl=3'b110) -> req0 served first (result 0, zero=1), then req1 (result 7, zero=0); rsp1_valid never overlaps rsp0_valid.
REQ-033 Both requesters valid for 6 ops, rsp ready high -> grant sequence 0,1,0,1,0,1, one accept every 3 cycles, ops_done=6.
REQ-034 rsp1_ready low 4 cycles in RESP (req1 OR 0/0xFFFFFFFF) -> rsp1_valid held, rsp_result=0xFFFFFFFF stable, both reqN_ready=0, ops_done unchanged until ready rises.
REQ-035 reset asserted in EXEC -> next cycle IDLE, no rspN_valid, all outputs at reset values, ops_done=0.
REQ-036 Preload via 65536 consumed ops (or force) -> ops_done wraps 0xFFFF -> 0x0000.
